// File: rtl/eoc_monitor.sv
// eoc_monitor - end-of-computation monitor on the safety island peripheral bus.
//
// Software on the hart writes its exit status to the EOC register after the
// host has loaded the binary and resumed the hart. The block latches the exit
// code, raises eoc_o, counts the cycles spent running and (optionally) trips
// a watchdog when the run exceeds the TIMEOUT limit.
//
// Optional feature macro: SAFETY_ISLAND_EOC_WATCHDOG_EN
//   defined   : TIMEOUT register and TIMEOUT state are present.
//   undefined : no watchdog; timeout_o is 0, offset 0x8 reads 0 and ignores writes.
//
// Ports:
//   clk_i        clock
//   rst_i        synchronous active-high reset
//   start_i      one-cycle pulse when the hart is resumed; arms the monitor
//   req_i        bus request (always granted)
//   we_i         write enable
//   addr_i       byte address, only bits [3:2] are decoded
//   be_i         byte enables
//   wdata_i      write data
//   gnt_o        grant, equal to req_i
//   rvalid_o     response valid, one cycle after each request
//   rdata_o      read data, 0 when rvalid_o is low
//   err_o        response error, meaningful with rvalid_o
//   eoc_o        high while the run has ended with a done write
//   exit_code_o  latched exit code
//   timeout_o    high while the watchdog has tripped
//
// Register map (word offsets):
//   0x0 EOC     (W)  bit31 done, bits30:0 code; reads {eoc_o, exit_code_o}
//   0x4 STATUS  (RO) bit0 running, bit1 done, bit2 timeout
//   0x8 TIMEOUT (RW) byte-masked watchdog limit, 0 disables
//   0xC CYCLE   (RO) cycles spent in RUNNING, saturating
module eoc_monitor #(
  parameter int unsigned         AddrWidth      = 32,
  parameter int unsigned         CntWidth       = 32,
  parameter logic [CntWidth-1:0] DefaultTimeout = 32'h00FF_FFFF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 req_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [3:0]           be_i,
  input  logic [31:0]          wdata_i,
  output logic                 gnt_o,
  output logic                 rvalid_o,
  output logic [31:0]          rdata_o,
  output logic                 err_o,
  output logic                 eoc_o,
  output logic [30:0]          exit_code_o,
  output logic                 timeout_o
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRunning = 2'd1,
    StDone    = 2'd2,
    StTimeout = 2'd3
  } state_e;

  localparam logic [CntWidth-1:0] CntZero = {CntWidth{1'b0}};
  localparam logic [CntWidth-1:0] CntOne  = {{(CntWidth-1){1'b0}}, 1'b1};
  localparam logic [CntWidth-1:0] CntMax  = {CntWidth{1'b1}};
  localparam int unsigned         TmoBits = (CntWidth < 32) ? CntWidth : 32;

  state_e              state_q;
  logic [CntWidth-1:0] cycle_q;
  logic [CntWidth-1:0] cycle_inc_s;
  logic [30:0]         code_q;
  logic [30:0]         exit_code_q;
  logic                eoc_q;
  logic                running_q;
  logic                timeout_q;
  logic                rvalid_q;
  logic                err_q;
  logic [31:0]         rdata_q;

  logic [1:0]          sel_s;
  logic                wr_s;
  logic                rd_s;
  logic                full_be_s;
  logic                done_wr_s;
  logic                wd_fire_s;
  logic                timeout_flag_s;
  logic [31:0]         tmo_rd_s;
  logic                err_d;
  logic [31:0]         rdata_d;
  logic                unused_s;

  assign gnt_o     = req_i;
  assign sel_s     = addr_i[3:2];
  // A write with no byte lanes enabled is a no-op on every register.
  assign wr_s      = req_i & we_i & (be_i != 4'h0);
  assign rd_s      = req_i & ~we_i;
  assign full_be_s = (be_i == 4'hF);
  assign done_wr_s = wr_s & (sel_s == 2'd0) & full_be_s & wdata_i[31];

  assign cycle_inc_s = (cycle_q == CntMax) ? cycle_q : (cycle_q + CntOne);

`ifdef SAFETY_ISLAND_EOC_WATCHDOG_EN
  logic [CntWidth-1:0] tmo_q;
  logic [CntWidth-1:0] tmo_d;

  // Byte-masked next value of the TIMEOUT limit.
  always_comb begin
    tmo_d = tmo_q;
    if (wr_s && (sel_s == 2'd2)) begin
      for (int i = 0; i < int'(TmoBits); i++) begin
        if (be_i[i/8]) begin
          tmo_d[i] = wdata_i[i];
        end else begin
          tmo_d[i] = tmo_q[i];
        end
      end
    end else begin
      tmo_d = tmo_q;
    end
  end

  // TIMEOUT limit register; the compare sees a write from the next cycle on.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmo_q <= DefaultTimeout;
    end else begin
      tmo_q <= tmo_d;
    end
  end

  assign wd_fire_s      = (state_q == StRunning) && (tmo_q != CntZero) && (cycle_q == tmo_q);
  assign tmo_rd_s       = 32'(tmo_q);
  assign timeout_flag_s = timeout_q;
  assign unused_s       = ^addr_i;
`else
  assign wd_fire_s      = 1'b0;
  assign tmo_rd_s       = 32'h0000_0000;
  assign timeout_flag_s = 1'b0;
  assign unused_s       = ^{addr_i, DefaultTimeout, timeout_q};
`endif

  // Response error decode for the current request.
  always_comb begin
    err_d = 1'b0;
    if (wr_s) begin
      case (sel_s)
        2'd0: begin
          // A done write only counts while RUNNING; a restart in the same
          // cycle drops it silently because the state is still RUNNING.
          if (!full_be_s) begin
            err_d = 1'b1;
          end else if (wdata_i[31] && (state_q != StRunning)) begin
            err_d = 1'b1;
          end else begin
            err_d = 1'b0;
          end
        end
        2'd1:    err_d = 1'b1;
        2'd2:    err_d = 1'b0;
        2'd3:    err_d = 1'b1;
        default: err_d = 1'b0;
      endcase
    end else begin
      err_d = 1'b0;
    end
  end

  // Read data mux; status reflects the registered outputs.
  always_comb begin
    rdata_d = 32'h0000_0000;
    if (rd_s) begin
      case (sel_s)
        2'd0:    rdata_d = {eoc_q, exit_code_q};
        2'd1:    rdata_d = {29'h0000_0000, timeout_flag_s, eoc_q, running_q};
        2'd2:    rdata_d = tmo_rd_s;
        2'd3:    rdata_d = 32'(cycle_q);
        default: rdata_d = 32'h0000_0000;
      endcase
    end else begin
      rdata_d = 32'h0000_0000;
    end
  end

  // Run state machine, cycle counter, bus response and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      cycle_q     <= CntZero;
      code_q      <= 31'h0000_0000;
      exit_code_q <= 31'h0000_0000;
      eoc_q       <= 1'b0;
      running_q   <= 1'b0;
      timeout_q   <= 1'b0;
      rvalid_q    <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= 32'h0000_0000;
    end else begin
      rvalid_q    <= req_i;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      eoc_q       <= (state_q == StDone);
      running_q   <= (state_q == StRunning);
      timeout_q   <= (state_q == StTimeout);
      exit_code_q <= code_q;
      case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q <= StRunning;
            cycle_q <= CntZero;
            code_q  <= 31'h0000_0000;
          end
        end
        StRunning: begin
          if (start_i) begin
            cycle_q <= CntZero;
            code_q  <= 31'h0000_0000;
          end else if (done_wr_s) begin
            state_q <= StDone;
            cycle_q <= cycle_inc_s;
            code_q  <= wdata_i[30:0];
          end else if (wd_fire_s) begin
            state_q <= StTimeout;
            cycle_q <= cycle_inc_s;
            code_q  <= 31'h7FFF_FFFF;
          end else begin
            cycle_q <= cycle_inc_s;
          end
        end
        StDone, StTimeout: begin
          if (start_i) begin
            state_q <= StRunning;
            cycle_q <= CntZero;
            code_q  <= 31'h0000_0000;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign rvalid_o    = rvalid_q;
  assign err_o       = err_q;
  assign rdata_o     = rdata_q;
  assign eoc_o       = eoc_q;
  assign exit_code_o = exit_code_q;
  assign timeout_o   = timeout_flag_s;

endmodule

// File: tb/tb_eoc_monitor.sv
// Self-checking bench for eoc_monitor: a run-level model checked every cycle
// plus hand-computed expectations for the key scenarios.
module tb_eoc_monitor;

`ifdef SAFETY_ISLAND_EOC_WATCHDOG_EN
  localparam bit WdEn = 1'b1;
`else
  localparam bit WdEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, start, req, we;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  be;
  logic        gnt, rvalid, err, eoc, tmo_o;
  logic [30:0] code;

  always #5 clk = ~clk;

  eoc_monitor dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .req_i(req), .we_i(we),
    .addr_i(addr), .be_i(be), .wdata_i(wdata), .gnt_o(gnt), .rvalid_o(rvalid),
    .rdata_o(rdata), .err_o(err), .eoc_o(eoc), .exit_code_o(code), .timeout_o(tmo_o)
  );

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // Model: run mode 0 idle, 1 running, 2 done, 3 timed out.
  int          m_mode;
  logic [31:0] m_cyc, m_tmo;
  logic [30:0] m_code;
  logic        e_rvalid, e_err, e_eoc, e_to, e_run;
  logic [31:0] e_rdata;
  logic [30:0] e_code;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input logic [31:0] act,
                             input logic [31:0] lo, input logic [31:0] hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
    end
  endtask

  // Advance the model by one clock edge using the inputs the DUT samples.
  task automatic model_step();
    logic [31:0] rd;
    logic        er, done, fire;
    if (rst) begin
      m_mode = 0; m_cyc = 32'h0; m_code = 31'h0; m_tmo = 32'h00FF_FFFF;
      e_rvalid = 1'b0; e_err = 1'b0; e_rdata = 32'h0;
      e_eoc = 1'b0; e_to = 1'b0; e_run = 1'b0; e_code = 31'h0;
    end else begin
      rd = 32'h0;
      er = 1'b0;
      if (req && !we) begin
        case (addr[3:2])
          2'd0:    rd = {e_eoc, e_code};
          2'd1:    rd = {29'h0, e_to, e_eoc, e_run};
          2'd2:    rd = WdEn ? m_tmo : 32'h0;
          default: rd = m_cyc;
        endcase
      end
      if (req && we && be != 4'h0) begin
        case (addr[3:2])
          2'd0:    er = (be != 4'hF) || (wdata[31] && m_mode != 1);
          2'd2:    er = 1'b0;
          default: er = 1'b1;
        endcase
      end
      e_rvalid = req; e_rdata = rd; e_err = er;
      e_eoc = (m_mode == 2); e_to = (m_mode == 3); e_run = (m_mode == 1); e_code = m_code;
      done = req && we && addr[3:2] == 2'd0 && be == 4'hF && wdata[31];
      fire = WdEn && m_mode == 1 && m_tmo != 32'h0 && m_cyc == m_tmo;
      if (req && we && addr[3:2] == 2'd2) begin
        for (int i = 0; i < 4; i++) if (be[i]) m_tmo[8*i +: 8] = wdata[8*i +: 8];
      end
      if (start) begin
        m_mode = 1; m_cyc = 32'h0; m_code = 31'h0;
      end else if (m_mode == 1) begin
        if (m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 32'd1;
        if (done) begin
          m_mode = 2; m_code = wdata[30:0];
        end else if (fire) begin
          m_mode = 3; m_code = 31'h7FFF_FFFF;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // One-cycle bus access; returns the response seen in the following cycle.
  task automatic bus(input logic w, input logic [3:0] off, input logic [3:0] b,
                     input logic [31:0] d, output logic [31:0] rd, output logic er);
    req = 1'b1; we = w; addr = {28'h0, off}; be = b; wdata = d;
    tick();
    req = 1'b0; we = 1'b0; addr = 32'h0; be = 4'h0; wdata = 32'h0; start = 1'b0;
    rd = rdata; er = err;
  endtask

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("gnt", {31'h0, gnt}, {31'h0, req});
      check("rvalid", {31'h0, rvalid}, {31'h0, e_rvalid});
      if (e_rvalid) check("err", {31'h0, err}, {31'h0, e_err});
      check("rdata", rdata, e_rdata);
      check("eoc", {31'h0, eoc}, {31'h0, e_eoc});
      check("exit_code", {1'b0, code}, {1'b0, e_code});
      check("timeout", {31'h0, tmo_o}, {31'h0, e_to});
    end
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          n;
    rst = 1'b1; start = 1'b0; req = 1'b0; we = 1'b0; addr = 32'h0; be = 4'h0; wdata = 32'h0;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    check("reset_eoc", {31'h0, eoc}, 32'h0);
    check("reset_rvalid", {31'h0, rvalid}, 32'h0);
    check("reset_code", {1'b0, code}, 32'h0);

    // Normal run of 100 cycles ending with exit code 0.
    start = 1'b1; tick(); start = 1'b0;
    ticks(100);
    bus(1'b1, 4'h0, 4'hF, 32'h8000_0000, rd, er);
    check("done_wr_err", {31'h0, er}, 32'h0);
    check("eoc_not_yet", {31'h0, eoc}, 32'h0);
    tick();
    check("eoc_two_after", {31'h0, eoc}, 32'h1);
    check("exit_code_zero", {1'b0, code}, 32'h0);
    bus(1'b0, 4'hC, 4'hF, 32'h0, rd, er);
    check_range("cycle_count", rd, 32'd98, 32'd102);
    ticks(5);
    bus(1'b0, 4'hC, 4'hF, 32'h0, rd, er);
    check("cycle_frozen", rd, 32'd101);

    // Exit code 5, then a restart clears it.
    start = 1'b1; tick(); start = 1'b0;
    ticks(3);
    bus(1'b1, 4'h0, 4'hF, 32'h8000_0005, rd, er);
    ticks(2);
    check("exit_code_5", {1'b0, code}, 32'd5);
    bus(1'b0, 4'h0, 4'hF, 32'h0, rd, er);
    check("eoc_reg_read", rd, 32'h8000_0005);
    start = 1'b1; tick(); start = 1'b0;
    ticks(2);
    check("restart_eoc", {31'h0, eoc}, 32'h0);
    check("restart_code", {1'b0, code}, 32'h0);
    bus(1'b0, 4'h4, 4'hF, 32'h0, rd, er);
    check("restart_status", rd, 32'h1);

    // Heartbeat, partial write, read-only writes, empty byte enables.
    bus(1'b1, 4'h0, 4'hF, 32'h0000_0007, rd, er);
    check("heartbeat_err", {31'h0, er}, 32'h0);
    bus(1'b1, 4'h0, 4'h1, 32'h8000_0003, rd, er);
    check("partial_err", {31'h0, er}, 32'h1);
    ticks(2);
    bus(1'b0, 4'h4, 4'hF, 32'h0, rd, er);
    check("partial_still_running", rd, 32'h1);
    bus(1'b1, 4'h4, 4'hF, 32'h0000_0002, rd, er);
    check("status_wr_err", {31'h0, er}, 32'h1);
    bus(1'b1, 4'hC, 4'hF, 32'h0000_0000, rd, er);
    check("cycle_wr_err", {31'h0, er}, 32'h1);
    bus(1'b1, 4'h4, 4'h0, 32'h0000_0002, rd, er);
    check("be0_no_err", {31'h0, er}, 32'h0);
    bus(1'b1, 4'h8, 4'hF, 32'h00FF_FFFF, rd, er);
    check("timeout_wr_no_err", {31'h0, er}, 32'h0);

    // Restart and done write in the same cycle: restart wins.
    start = 1'b1;
    bus(1'b1, 4'h0, 4'hF, 32'h8000_0009, rd, er);
    check("start_wins_err", {31'h0, er}, 32'h0);
    ticks(2);
    check("start_wins_eoc", {31'h0, eoc}, 32'h0);

    // Back-to-back STATUS reads.
    req = 1'b1; we = 1'b0; addr = 32'h4; be = 4'hF;
    tick();
    check("b2b_rvalid0", {31'h0, rvalid}, 32'h1);
    check("b2b_rdata0", rdata, 32'h1);
    tick();
    req = 1'b0; addr = 32'h0; be = 4'h0;
    check("b2b_rvalid1", {31'h0, rvalid}, 32'h1);
    check("b2b_rdata1", rdata, 32'h1);
    tick();
    check("b2b_idle", {31'h0, rvalid}, 32'h0);

    // Reset while DONE, on the cycle after a read request.
    bus(1'b1, 4'h0, 4'hF, 32'h8000_0002, rd, er);
    ticks(2);
    check("pre_reset_eoc", {31'h0, eoc}, 32'h1);
    bus(1'b0, 4'h0, 4'hF, 32'h0, rd, er);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("reset_rvalid_cancel", {31'h0, rvalid}, 32'h0);
    check("reset_eoc_cleared", {31'h0, eoc}, 32'h0);
    bus(1'b0, 4'h8, 4'hF, 32'h0, rd, er);
`ifdef SAFETY_ISLAND_EOC_WATCHDOG_EN
    check("reset_timeout_reg", rd, 32'h00FF_FFFF);
`else
    check("timeout_reg_absent", rd, 32'h0);
`endif

    // Done write while IDLE is refused.
    bus(1'b1, 4'h0, 4'hF, 32'h8000_0001, rd, er);
    check("idle_done_err", {31'h0, er}, 32'h1);
    ticks(2);
    check("idle_eoc", {31'h0, eoc}, 32'h0);
    check("idle_code", {1'b0, code}, 32'h0);

`ifdef SAFETY_ISLAND_EOC_WATCHDOG_EN
    // Watchdog: byte-masked limit, trip, done priority, disable.
    bus(1'b1, 4'h8, 4'hF, 32'd50, rd, er);
    bus(1'b1, 4'h8, 4'h2, 32'h0000_AB00, rd, er);
    bus(1'b0, 4'h8, 4'hF, 32'h0, rd, er);
    check("timeout_byte_wr", rd, 32'h0000_AB32);
    bus(1'b1, 4'h8, 4'hF, 32'd50, rd, er);
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (!tmo_o && n < 200) begin
      tick();
      n++;
    end
    check_range("watchdog_latency", n, 32'd50, 32'd53);
    check("watchdog_code", {1'b0, code}, 32'h7FFF_FFFF);
    bus(1'b0, 4'h4, 4'hF, 32'h0, rd, er);
    check("watchdog_status", rd, 32'h4);
    bus(1'b1, 4'h8, 4'hF, 32'd20, rd, er);
    start = 1'b1; tick(); start = 1'b0;
    ticks(20);
    bus(1'b1, 4'h0, 4'hF, 32'h8000_0004, rd, er);
    tick();
    check("done_beats_timeout_eoc", {31'h0, eoc}, 32'h1);
    check("done_beats_timeout_to", {31'h0, tmo_o}, 32'h0);
    check("done_beats_timeout_code", {1'b0, code}, 32'd4);
    bus(1'b1, 4'h8, 4'hF, 32'd0, rd, er);
    start = 1'b1; tick(); start = 1'b0;
    ticks(10000);
    check("watchdog_disabled", {31'h0, tmo_o}, 32'h0);
    bus(1'b0, 4'h4, 4'hF, 32'h0, rd, er);
    check("watchdog_disabled_status", rd, 32'h1);
`endif

    ticks(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/eoc_monitor.md
Name: eoc_monitor

Overview:
- Memory-mapped end-of-computation (EOC) monitor on the safety island peripheral bus.
- Software running on the hart writes its exit status here after the host has loaded the binary and resumed the hart over JTAG.
- The block latches the exit code, raises eoc_o, and exposes status to both the core and the debug/host side.
- It also counts run cycles and provides an optional watchdog timeout.

Parameters:
- AddrWidth, 32, bus address width; only addr_i[3:2] are decoded.
- CntWidth, 32, width of the cycle counter and the timeout limit register.
- DefaultTimeout, 32'h00FF_FFFF, reset value of the TIMEOUT register.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- start_i  in  1  one-cycle pulse when the hart is resumed; arms the monitor
- req_i  in  1  bus request
- we_i  in  1  write enable
- addr_i  in  AddrWidth  byte address
- be_i  in  4  byte enables
- wdata_i  in  32  write data
- gnt_o  out  1  grant
- rvalid_o  out  1  response valid
- rdata_o  out  32  read data
- err_o  out  1  response error (valid with rvalid_o)
- eoc_o  out  1  level; high while in DONE
- exit_code_o  out  31  latched exit code
- timeout_o  out  1  level; high while in TIMEOUT

Behaviour:
- Reset is synchronous and active-high. On reset:
  - state=IDLE; CYCLE=0; TIMEOUT=DefaultTimeout; exit code=0.
  - All outputs 0, including rvalid_o and err_o.
- Bus timing:
  - gnt_o = req_i (combinational, always granted).
  - rvalid_o is asserted exactly 1 cycle after each granted request, for reads and writes alike.
  - rdata_o and err_o are valid only when rvalid_o=1; otherwise rdata_o=0.
- Register map (word offsets):
  - 0x0 EOC (W): bit31=done, bits30:0=code. Reads return {eoc_o, exit_code_o}.
  - 0x4 STATUS (RO): bit0=running, bit1=done, bit2=timeout, rest 0. Writes set err_o=1 and have no effect.
  - 0x8 TIMEOUT (RW): be_i-masked byte writes.
  - 0xC CYCLE (RO): cycles spent in RUNNING. Writes set err_o=1.
  - Any access with be_i=0 completes with no side effect and err_o=0.
- State machine:
  - IDLE:
    - start_i -> RUNNING; clear CYCLE to 0.
    - An EOC write with done=1 while IDLE is ignored (err_o=1); the exit code is not latched.
  - RUNNING:
    - CYCLE increments every cycle and saturates at all-ones (no wrap).
    - An EOC write with done=1 and be_i=4'hF -> DONE next cycle; code latched, eoc_o=1 from the following cycle.
    - An EOC write with done=0 is accepted and has no effect (heartbeat).
    - A partial-be_i EOC write returns err_o=1 and does not terminate the run.
  - DONE: sticky; CYCLE frozen; only rst_i or start_i leaves (start_i -> RUNNING, clears eoc_o, exit code and CYCLE).
  - TIMEOUT: see Optional Feature; sticky; leaves like DONE.
- Simultaneous events:
  - start_i and an EOC done write in the same cycle while RUNNING: start_i wins; the run restarts and the write is dropped, but its rvalid_o still returns with err_o=0.
  - An EOC done write in the cycle the timeout fires: DONE wins.
- Reset mid-operation: any state -> IDLE next edge. A pending rvalid_o is cancelled (0 after reset).
- Register update timing: a TIMEOUT write takes effect for the comparison on the cycle after the write.

Optional Feature:
- Macro: SAFETY_ISLAND_EOC_WATCHDOG_EN.
- Defined:
  - In RUNNING, when CYCLE == TIMEOUT and no done write occurs that cycle -> TIMEOUT state; timeout_o=1 and exit code forced to 31'h7FFF_FFFF.
  - TIMEOUT=0 disables the watchdog.
- Undefined:
  - No TIMEOUT state; timeout_o tied 0; STATUS bit2 reads 0.
  - 0x8 reads 0 and writes are accepted silently (err_o=0).

Test Plan:
- Reset then start_i, run 100 cycles, write 0x8000_0000 to 0x0 -> eoc_o=1 and exit_code_o=0 two cycles after the request; CYCLE read equals 100±2 and is then frozen.
- RUNNING, write 0x8000_0005 -> exit_code_o=5. A second start_i pulse -> eoc_o=0, exit_code_o=0, STATUS=0x1.
- Watchdog defined: TIMEOUT=50, start_i -> timeout_o=1 after 50 RUNNING cycles and exit_code_o=0x7FFF_FFFF. With TIMEOUT=0, no timeout after 10000 cycles.
- IDLE write 0x8000_0001 -> err_o=1, eoc_o stays 0. Write to STATUS -> err_o=1. Partial be_i=4'h1 EOC write while RUNNING -> err_o=1, still RUNNING.
- Assert rst_i while DONE and on the cycle after a read request -> rvalid_o=0, eoc_o=0, TIMEOUT reads back 0x00FF_FFFF.
- Back-to-back reads of 0x4 on consecutive cycles -> rvalid_o high on 2 consecutive cycles with correct data each time.
